// File: rtl/sfifo_wr_if_top_if.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_wr_if_top_if
// Purpose  : WISHBONE slave bus plus FIFO write-port bundle for sfifo_wr_if_top.
// Revision : 1.0
// ============================================================================
interface sfifo_wr_if_top_if #(
  parameter int WB_LAW   = 5,
  parameter int WB_DW    = 32,
  parameter int SFIFO_DW = 16
) ();
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [3:0]          wb_sel_i;
  logic [WB_LAW-1:0]   wb_adr_i;
  logic [WB_DW-1:0]    wb_dat_i;
  logic [WB_DW-1:0]    wb_dat_o;
  logic                wb_ack_o;
  logic                sfifo_wr_o;
  logic [SFIFO_DW-1:0] sfifo_do;
  logic                sfifo_full_i;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, sfifo_full_i,
    output wb_dat_o, wb_ack_o, sfifo_wr_o, sfifo_do
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, sfifo_full_i,
    input  wb_dat_o, wb_ack_o, sfifo_wr_o, sfifo_do
  );
endinterface
`default_nettype wire

// File: rtl/sfifo_wr_if_top.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_wr_if_top
// Purpose  : WISHBONE slave pushing CPU words into a SYNC_FIFO write port,
//            with push counter and sticky abort flag. Optional half-word
//            packing controlled by macro SFIFO_WR_PACK_EN.
// Revision : 1.0
// ============================================================================
module sfifo_wr_if_top (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_n_i,
  sfifo_wr_if_top_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_LO = 3'd1,
    ST_HOLD    = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  localparam logic [2:0] c_OFF_PUSH_CNT = 3'd0;
  localparam logic [2:0] c_OFF_STATUS   = 3'd1;
  localparam logic [2:0] c_OFF_DO       = 3'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dat;
  logic [31:0] r_dat_o;
  logic [31:0] r_push_cnt;
  logic        r_hi_pend;
  logic        r_abort;

  logic [2:0]  w_off;
  logic        w_req;
  logic        w_idle_req;
  logic        w_do_wr;
  logic        w_push;
  logic        w_set_abort;
  logic        w_lo_sel;
  logic        w_hi_sel;
  logic        w_pack_en;
  logic [31:0] w_rd_data;
  logic        w_unused;

`ifdef SFIFO_WR_PACK_EN
  // A half is pushed only when both of its byte lanes are selected.
  assign w_lo_sel  = (bus.wb_sel_i[1:0] == 2'b11);
  assign w_hi_sel  = (bus.wb_sel_i[3:2] == 2'b11);
  assign w_pack_en = 1'b1;
  assign w_unused  = ^bus.wb_adr_i[1:0];
`else
  assign w_lo_sel  = 1'b1;
  assign w_hi_sel  = 1'b0;
  assign w_pack_en = 1'b0;
  assign w_unused  = ^{bus.wb_adr_i[1:0], bus.wb_sel_i};
`endif

  assign w_off      = bus.wb_adr_i[4:2];
  assign w_req      = bus.wb_cyc_i & bus.wb_stb_i & (r_state != ST_ACK);
  assign w_idle_req = w_req & (r_state == ST_IDLE);
  assign w_do_wr    = w_req & bus.wb_we_i & (w_off == c_OFF_DO);
  assign w_push     = (r_state == ST_PUSH_LO) | (r_state == ST_PUSH_HI);

  always_comb begin
    w_rd_data = 32'd0;
    case (w_off)
      c_OFF_PUSH_CNT: w_rd_data = r_push_cnt;
      c_OFF_STATUS:   w_rd_data = {29'd0, r_abort, w_pack_en, bus.sfifo_full_i};
      default:        w_rd_data = 32'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_do_wr) begin
          // A full FIFO simply holds the bus; the master waits as long as needed.
          if (!bus.sfifo_full_i) begin
            if (w_lo_sel)      w_state_nxt = ST_PUSH_LO;
            else if (w_hi_sel) w_state_nxt = ST_PUSH_HI;
            else               w_state_nxt = ST_ACK;
          end
        end else if (w_req) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_PUSH_LO: w_state_nxt = r_hi_pend ? ST_HOLD : ST_ACK;
      ST_HOLD: begin
        if (!bus.wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_set_abort = 1'b1;
        end else if (!bus.sfifo_full_i) begin
          w_state_nxt = ST_PUSH_HI;
        end
      end
      ST_PUSH_HI: w_state_nxt = ST_ACK;
      ST_ACK:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_dat      <= 32'd0;
      r_hi_pend  <= 1'b0;
      r_dat_o    <= 32'd0;
      r_push_cnt <= 32'd0;
      r_abort    <= 1'b0;
    end else begin
      if (w_idle_req && w_do_wr && !bus.sfifo_full_i) begin
        r_dat     <= bus.wb_dat_i;
        r_hi_pend <= w_lo_sel & w_hi_sel;
      end

      if (w_idle_req && !bus.wb_we_i) begin
        r_dat_o <= w_rd_data;
      end

      // Clears come only from IDLE and pushes only from PUSH_*, so they never collide.
      if (w_idle_req && bus.wb_we_i && (w_off == c_OFF_PUSH_CNT)) begin
        r_push_cnt <= 32'd0;
      end else if (w_push) begin
        r_push_cnt <= r_push_cnt + 32'd1;
      end

      if (w_set_abort) begin
        r_abort <= 1'b1;
      end else if (w_idle_req && bus.wb_we_i && (w_off == c_OFF_STATUS) && bus.wb_dat_i[2]) begin
        r_abort <= 1'b0;
      end
    end
  end

  assign bus.wb_ack_o   = (r_state == ST_ACK);
  assign bus.wb_dat_o   = r_dat_o;
  assign bus.sfifo_wr_o = w_push;
  assign bus.sfifo_do   = (r_state == ST_PUSH_HI) ? r_dat[31:16] :
                          (r_state == ST_PUSH_LO) ? r_dat[15:0]  : 16'd0;

endmodule
`default_nettype wire
